// File: rtl/mem_nport.sv
// mem_nport -- unified memory with NR synchronous read ports and one write
// port, all sharing one array. After reset, a clear engine can zero the array
// before normal operation begins.
//
// Ports:
//   clk       clock; all state changes on the rising edge
//   reset     synchronous, active-high
//   r_en      [NR]          read enable, bit i = port i
//   r_addr    [NR*ADDR_W]   read address of port i at [i*ADDR_W +: ADDR_W]
//   r_data    [NR*DATA_W]   read data of port i at [i*DATA_W +: DATA_W]
//   r_valid   [NR]          r_data of port i was updated by the last edge
//   w_en      write enable
//   w_addr    [ADDR_W]      write address
//   w_data    [DATA_W]      write data
//   busy      clear engine running; read and write requests are ignored
//   addr_err  [NR+1]        one-cycle pulse: bit i = read port i out of range,
//                           bit NR = write out of range
module mem_nport #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 65536,
  parameter int NR           = 2,
  parameter bit WRITE_FIRST  = 1'b1,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NR-1:0]        r_en,
  input  logic [NR*ADDR_W-1:0] r_addr,
  output logic [NR*DATA_W-1:0] r_data,
  output logic [NR-1:0]        r_valid,
  input  logic                 w_en,
  input  logic [ADDR_W-1:0]    w_addr,
  input  logic [DATA_W-1:0]    w_data,
  output logic                 busy,
  output logic [NR:0]          addr_err
);

  localparam int CLR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CLR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rd_word [NR];
  logic               w_ok;

  // Compare one bit wider than the address so that DEPTH == 2**ADDR_W
  // makes every address in range rather than overflowing the constant.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR_ON_RST ? S_CLEAR : S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: each always_comb assigns its outputs a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_addr == CLR_W'(DEPTH - 1)) state_nxt = S_IDLE;
  end

  always_comb begin
    busy = 1'b0;
    if (state == S_CLEAR) busy = 1'b1;
  end

  // Sweep pointer of the clear engine; restarts from 0 on every reset.
  always_ff @(posedge clk) begin
    if (reset)     clr_addr <= '0;
    else if (busy) clr_addr <= clr_addr + 1'b1;
  end

  // ---------------------------------------------------------------- array
  assign w_ok = w_en && in_range(w_addr);

  // NOTE: the array itself has no reset term; zeroing is done by the clear
  // engine one word per cycle, so the storage can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy)      mem[clr_addr]              <= '0;
      else if (w_ok) mem[w_addr[CLR_W-1:0]]     <= w_data;
    end
  end

  // Word each port would capture: zero when out of range, the incoming write
  // data on a same-address collision in write-first mode, else the array.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rd_word[i] = '0;
      if (in_range(r_addr[i*ADDR_W +: ADDR_W])) begin
        if (WRITE_FIRST && w_en && (w_addr == r_addr[i*ADDR_W +: ADDR_W]))
          rd_word[i] = w_data;
        else
          rd_word[i] = mem[r_addr[i*ADDR_W +: CLR_W]];
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= '0;
      r_valid  <= '0;
      addr_err <= '0;
    end else if (busy) begin
      r_valid  <= '0;
      addr_err <= '0;
    end else begin
      addr_err[NR] <= w_en && !in_range(w_addr);
      for (int i = 0; i < NR; i++) begin
        r_valid[i]  <= r_en[i];
        addr_err[i] <= r_en[i] && !in_range(r_addr[i*ADDR_W +: ADDR_W]);
        if (r_en[i]) r_data[i*DATA_W +: DATA_W] <= rd_word[i];
      end
    end
  end

endmodule
